icache_dm: RTL and testbench

Parametrised direct-mapped, read-only instruction cache between the fetch stage and a slower backing instruction memory. It replaces the flat, combinational, preloaded instruction array with a tagged line store. Hits return one cycle after acceptance. Misses run a line-refill state machine over a valid/ready request channel followed by an in-order beat stream. It also supports whole-cache flush (for self-modifying code or program reload) and provides hit/miss performance counters.

---
 rtl/icache_dm.sv | 144 ++++++++++++++
 tb/tb_icache_dm.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache with line refill, flush and hit/miss counters
module icache_dm #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_instr,
    output logic [ADDR_W-1:0] resp_pc,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int OFF_W    = $clog2(WORDS_PER_LINE);
    localparam int IDX_W    = $clog2(NUM_LINES);
    localparam int LINE_LSB = OFF_W + 2;
    localparam int TAG_LSB  = LINE_LSB + IDX_W;
    localparam int TAG_W    = ADDR_W - TAG_LSB;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_LSB) - ADDR_W'(1));
    localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        REFILL_REQ,
        REFILL_DATA,
        RESPOND
    } state_t;

    state_t state, state_nxt;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags [NUM_LINES];
    logic [DATA_W-1:0]    data [NUM_LINES][WORDS_PER_LINE];

    logic [ADDR_W-1:0] req_pc;
    logic [OFF_W-1:0]  beat_cnt;
    logic              flush_pend;

    logic [ADDR_W-1:0] pc_word;
    logic [OFF_W-1:0]  f_off, r_off;
    logic [IDX_W-1:0]  f_idx, r_idx;
    logic [TAG_W-1:0]  f_tag, r_tag;
    logic              hit, accept, beat, last_beat;
    logic [DATA_W-1:0] fill_word;

    assign pc_word = fetch_pc & WORD_MASK;
    assign f_off   = pc_word[LINE_LSB-1:2];
    assign f_idx   = pc_word[TAG_LSB-1:LINE_LSB];
    assign f_tag   = pc_word[ADDR_W-1:TAG_LSB];
    assign r_off   = req_pc[LINE_LSB-1:2];
    assign r_idx   = req_pc[TAG_LSB-1:LINE_LSB];
    assign r_tag   = req_pc[ADDR_W-1:TAG_LSB];

    assign fetch_ready   = (state == IDLE) && !flush;
    assign accept        = fetch_valid && fetch_ready;
    assign hit           = valid[f_idx] && (tags[f_idx] == f_tag);
    assign beat          = (state == REFILL_DATA) && mem_resp_valid;
    assign last_beat     = beat && (beat_cnt == LAST_BEAT);
    assign mem_req_valid = (state == REFILL_REQ);
    assign mem_req_addr  = req_pc & LINE_MASK;

    // Earlier beats are already in the array; only the final word must bypass it.
    assign fill_word = (r_off == LAST_BEAT) ? mem_resp_data : data[r_idx][r_off];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (accept && !hit) state_nxt = REFILL_REQ;
            REFILL_REQ:  if (mem_req_ready)  state_nxt = REFILL_DATA;
            REFILL_DATA: if (last_beat)      state_nxt = RESPOND;
            RESPOND:     state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= '0;
            flush_pend <= 1'b0;
            beat_cnt   <= '0;
            req_pc     <= '0;
            resp_valid <= 1'b0;
            resp_instr <= '0;
            resp_pc    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state      <= state_nxt;
            resp_valid <= 1'b0;

            if (accept && hit) begin
                resp_valid <= 1'b1;
                resp_instr <= data[f_idx][f_off];
                resp_pc    <= pc_word;
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end
            if (accept && !hit) begin
                req_pc <= pc_word;
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end

            if (state == REFILL_REQ && mem_req_ready) beat_cnt <= '0;
            if (beat) beat_cnt <= beat_cnt + OFF_W'(1);

            if (last_beat) begin
                valid[r_idx] <= 1'b1;
                resp_valid   <= 1'b1;
                resp_instr   <= fill_word;
                resp_pc      <= req_pc;
            end

            // A flush seen mid-miss waits until the response has gone out.
            if (state == RESPOND) begin
                flush_pend <= 1'b0;
                if (flush || flush_pend) valid <= '0;
            end else if (state == IDLE) begin
                if (flush) valid <= '0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && beat) data[r_idx][beat_cnt] <= mem_resp_data;
        if (rst_n && last_beat) tags[r_idx] <= r_tag;
    end

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - scoreboard bench for icache_dm with directed hit/miss/flush/reset vectors
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_pc = '0;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic [31:0] resp_pc;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_dm dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .resp_valid     (resp_valid),
        .resp_instr     (resp_instr),
        .resp_pc        (resp_pc),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          req_cycles = 0;
    int          rc;
    int          n;
    logic [63:0] exp_q[$];
    int          resp_cyc[$];
    logic [63:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every response pops the oldest expectation.
    initial forever begin
        @(negedge clk);
        if (mem_req_valid) req_cycles++;
        if (resp_valid) begin
            resp_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got pc %h instr %h want none", resp_pc, resp_instr);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_instr", resp_instr, mon_e[31:0]);
                check("resp_pc", resp_pc, mon_e[63:32]);
            end
        end
    end

    task automatic issue(input logic [31:0] pc);
        int k = 0;
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        @(negedge clk);
        while (!fetch_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (!fetch_ready) begin
            total++;
            bad++;
            $display("FAIL fetch_accept_timeout: got ready 0 want 1 pc %h", pc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input logic [31:0] pc, input logic [31:0] exp);
        exp_q.push_back({pc & ~32'h3, exp});
        issue(pc);
    endtask

    task automatic wait_req(input logic [31:0] line);
        int k = 0;
        @(negedge clk);
        while (!mem_req_valid && k < 20) begin
            k++;
            @(negedge clk);
        end
        check("mem_req_seen", 32'(mem_req_valid), 32'd1);
        check("mem_req_addr", mem_req_addr, line);
    endtask

    task automatic miss(input logic [31:0] pc, input logic [31:0] line, input logic [31:0] b0,
                        input logic [31:0] step, input logic [31:0] exp, input int stall,
                        input int flush_beat);
        exp_q.push_back({pc & ~32'h3, exp});
        issue(pc);
        fetch_valid = 1'b0;
        wait_req(line);
        for (int i = 0; i < stall; i++) begin
            check("stall_req_valid", 32'(mem_req_valid), 32'd1);
            check("stall_req_addr", mem_req_addr, line);
            check("stall_fetch_ready", 32'(fetch_ready), 32'd0);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = b0 + step * k;
            flush          = (k == flush_beat);
            @(posedge clk);
            #1;
        end
        mem_resp_valid = 1'b0;
        flush          = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mem_req_addr", mem_req_addr, 32'h0);
        check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);

        miss(32'h40, 32'h40, 32'h11, 32'h11, 32'h11, 0, -1);
        check("cold_miss_count", miss_count, 32'd1);

        rc = req_cycles;
        hit(32'h44, 32'h22);
        hit(32'h48, 32'h33);
        hit(32'h4C, 32'h44);
        fetch_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("stream_hit_count", hit_count, 32'd3);
        check("stream_no_mem_req", 32'(req_cycles), 32'(rc));
        n = resp_cyc.size();
        check("stream_back_to_back", 32'(resp_cyc[n-1] - resp_cyc[n-3]), 32'd2);

        miss(32'h440, 32'h440, 32'hA0, 32'h1, 32'hA0, 5, -1);
        miss(32'h40, 32'h40, 32'h11, 32'h11, 32'h11, 0, -1);
        check("conflict_miss_count", miss_count, 32'd3);

        flush       = 1'b1;
        fetch_valid = 1'b1;
        fetch_pc    = 32'h44;
        @(negedge clk);
        check("flush_blocks_ready", 32'(fetch_ready), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        fetch_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("flush_hit_count", hit_count, 32'd3);
        check("flush_miss_count", miss_count, 32'd3);

        miss(32'h4C, 32'h40, 32'h11, 32'h11, 32'h44, 0, -1);
        miss(32'h448, 32'h440, 32'hA0, 32'h1, 32'hA2, 0, 1);
        miss(32'h448, 32'h440, 32'hA0, 32'h1, 32'hA2, 0, -1);
        hit(32'h444, 32'hA1);
        fetch_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pending_flush_miss_count", miss_count, 32'd6);
        check("pending_flush_hit_count", hit_count, 32'd4);

        issue(32'h800);
        fetch_valid = 1'b0;
        wait_req(32'h800);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEAD0000 + k;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        mem_resp_data = 32'hDEAD0002;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_resp_instr", resp_instr, 32'h0);
        check("midrst_resp_pc", resp_pc, 32'h0);
        check("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("midrst_mem_req_addr", mem_req_addr, 32'h0);
        check("midrst_hit_count", hit_count, 32'd0);
        check("midrst_miss_count", miss_count, 32'd0);
        mem_resp_data = 32'hDEAD0003;
        @(posedge clk);
        #1 mem_resp_valid = 1'b0;
        @(posedge clk);
        #1;
        check("stray_beats_fetch_ready", 32'(fetch_ready), 32'd1);

        miss(32'h40, 32'h40, 32'h55, 32'h11, 32'h55, 0, -1);
        check("post_rst_miss_count", miss_count, 32'd1);
        check("post_rst_hit_count", hit_count, 32'd0);

        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            n++;
            @(posedge clk);
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
